btb_sa_core: RTL and testbench
==============================

Name: btb_sa_core

Overview:
Synthesizable, parametrised set-associative branch target buffer for the frontend. It is the RTL successor to the DPI-backed BTB harness model.
- Accepts one lookup and one update per cycle.
- Returns a registered prediction one cycle after each lookup.
- Adds optional history-hashed indexing, per-set round-robin replacement and a self-clearing init sequence after reset.

Parameters:
NSETS, 64, number of sets; power of two, >=2
NWAYS, 2, ways per set; power of two, >=1
TAG_BITS, 20, stored tag width
USE_HIST, 0, 1 = XOR low history bits into the set index

Ports:
clock  input  1  clock
reset  input  1  synchronous active-high reset
ready  output  1  high once init sweep is complete
req_valid  input  1  lookup request
req_pc  input  64  lookup PC
req_hist  input  64  global history for lookup
resp_valid  output  1  response valid (one cycle after req_valid)
resp_hit  output  1  lookup hit
resp_target  output  64  predicted target
resp_is_br  output  1  hit entry is conditional branch
resp_is_jal  output  1  hit entry is JAL
update_valid  input  1  write request
update_pc  input  64  PC being trained
update_hist  input  64  history at prediction time
update_target  input  64  resolved target
update_is_br  input  1  branch flag
update_is_jal  input  1  JAL flag

Behaviour:
- Reset and clock: reset is synchronous and active-high; clock is clock. All state is updated on the rising clock edge.
- Reset values: ready=0, resp_valid=0, resp_hit=0, resp_target=0, resp_is_br=0, resp_is_jal=0. All round-robin pointers are 0. FSM enters INIT with sweep index 0.
- INIT state:
  - Clears the valid bits of all ways in one set per cycle, sets 0..NSETS-1.
  - After NSETS cycles, moves to RUN; ready=1 from the first RUN cycle.
  - Reset asserted at any time, including mid-INIT or mid-RUN, restarts INIT from set 0.
- Behaviour during INIT:
  - req_valid still produces resp_valid=1 next cycle, with resp_hit=0 and the other outputs 0.
  - update_valid is ignored.
- Index: idx = req_pc[log2(NSETS)+1:2], XOR req_hist[log2(NSETS)-1:0] when USE_HIST=1. The update path uses update_pc and update_hist identically.
- Tag: pc[TAG_BITS+log2(NSETS)+1 : log2(NSETS)+2].
- Lookup:
  - Registered with 1-cycle latency. resp_valid is req_valid delayed by 1.
  - Hit = any way in the set is valid with a matching tag. If several ways match, the lowest-numbered way wins.
  - On a miss, resp_target, resp_is_br and resp_is_jal are 0.
  - When req_valid=0, resp_valid=0 and all resp fields are 0.
- Update, way selection:
  - If the tag is already present in the set, rewrite that way (target, flags); the pointer is unchanged.
  - Otherwise, write the way at the set's round-robin pointer, set its valid bit, then increment the pointer modulo NWAYS. The pointer wraps from NWAYS-1 to 0.
- Simultaneous lookup and update in the same cycle: the lookup reads pre-update contents (read-before-write) for any set, including the same set/tag.
- Widths: full 64-bit targets are stored. PC bits [1:0] are ignored.

Test Plan:
(All scenarios use defaults NSETS=64, NWAYS=2, TAG_BITS=20, USE_HIST=0.)
1. Assert reset 1 cycle, then release -> ready=0 for exactly 64 cycles, 1 on the 65th. A req_valid during INIT -> resp_valid=1, resp_hit=0 next cycle.
2. After ready: update pc=0x80001000, target=0x80002000, is_br=1. Next cycle, req pc=0x80001000 -> following cycle resp_hit=1, resp_target=0x80002000, resp_is_br=1, resp_is_jal=0.
3. Updates in order to pc 0x1000, 0x1100, 0x1200 (same set 0, distinct tags) -> lookup 0x1000 misses; 0x1100 and 0x1200 hit (0x1200 evicted way 0).
4. Same cycle: req pc=0x3000 and update pc=0x3000, target=0x4000, is_jal=1 -> response miss. A repeated req next cycle -> hit, target 0x4000, resp_is_jal=1.
5. Train 0x1000 then 0x1100 into set 0; re-update 0x1000 with target 0x5555 -> both still hit, 0x1000 returns 0x5555. Then a new update 0x1300 evicts way 0 (pointer unchanged by re-update).
6. Populate several entries, assert reset mid-RUN -> ready drops, and after 64 INIT cycles all previously trained PCs miss.

Source files
------------

// File: rtl/btb_sa_core.sv
// Set-associative BTB: one lookup and one update per cycle, prediction registered one cycle after lookup (read-before-write).
// No backpressure; ready stays low while the post-reset sweep clears one set per cycle.
module btb_sa_core #(
    parameter int NSETS    = 64,
    parameter int NWAYS    = 2,
    parameter int TAG_BITS = 20,
    parameter int USE_HIST = 0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        ready,
    input  logic        req_valid,
    input  logic [63:0] req_pc,
    input  logic [63:0] req_hist,
    output logic        resp_valid,
    output logic        resp_hit,
    output logic [63:0] resp_target,
    output logic        resp_is_br,
    output logic        resp_is_jal,
    input  logic        update_valid,
    input  logic [63:0] update_pc,
    input  logic [63:0] update_hist,
    input  logic [63:0] update_target,
    input  logic        update_is_br,
    input  logic        update_is_jal
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int WAY_W = (NWAYS > 1) ? $clog2(NWAYS) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic               running;

    logic [NWAYS-1:0]    valid_q  [NSETS];
    logic [TAG_BITS-1:0] tag_q    [NSETS][NWAYS];
    logic [63:0]         target_q [NSETS][NWAYS];
    logic                is_br_q  [NSETS][NWAYS];
    logic                is_jal_q [NSETS][NWAYS];
    logic [WAY_W-1:0]    rr_ptr_q [NSETS];

    logic [IDX_W-1:0]    req_idx, upd_idx;
    logic [TAG_BITS-1:0] req_tag, upd_tag;
    logic                lk_hit, upd_match;
    logic [WAY_W-1:0]    lk_way, upd_match_way, upd_way;

    assign req_idx = req_pc[IDX_W+1:2]    ^ ((USE_HIST != 0) ? req_hist[IDX_W-1:0]    : '0);
    assign upd_idx = update_pc[IDX_W+1:2] ^ ((USE_HIST != 0) ? update_hist[IDX_W-1:0] : '0);
    assign req_tag = req_pc[TAG_BITS+IDX_W+1:IDX_W+2];
    assign upd_tag = update_pc[TAG_BITS+IDX_W+1:IDX_W+2];
    assign running = (state_q == ST_RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ready   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (sweep_q == IDX_W'(NSETS - 1)) begin
                    state_d = ST_RUN;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_RUN: ready = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    // Lowest-numbered matching way wins, both for lookup and for update rewrite.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        upd_match = 1'b0;
        upd_match_way = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (!lk_hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (!upd_match && valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
                upd_match = 1'b1;
                upd_match_way = WAY_W'(w);
            end
        end
    end

    assign upd_way = upd_match ? upd_match_way : rr_ptr_q[upd_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_target <= '0;
            resp_is_br  <= 1'b0;
            resp_is_jal <= 1'b0;
            for (int s = 0; s < NSETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else begin
            resp_valid <= req_valid;
            if (req_valid && running && lk_hit) begin
                resp_hit    <= 1'b1;
                resp_target <= target_q[req_idx][lk_way];
                resp_is_br  <= is_br_q[req_idx][lk_way];
                resp_is_jal <= is_jal_q[req_idx][lk_way];
            end else begin
                resp_hit    <= 1'b0;
                resp_target <= '0;
                resp_is_br  <= 1'b0;
                resp_is_jal <= 1'b0;
            end
            if (update_valid && running && !upd_match) begin
                rr_ptr_q[upd_idx] <= (NWAYS == 1) ? '0 : rr_ptr_q[upd_idx] + 1'b1;
            end
        end
    end

    // Entry storage has no reset; the init sweep invalidates it instead.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!running) begin
                valid_q[sweep_q] <= '0;
            end else if (update_valid) begin
                valid_q[upd_idx][upd_way]  <= 1'b1;
                tag_q[upd_idx][upd_way]    <= upd_tag;
                target_q[upd_idx][upd_way] <= update_target;
                is_br_q[upd_idx][upd_way]  <= update_is_br;
                is_jal_q[upd_idx][upd_way] <= update_is_jal;
            end
        end
    end

endmodule

// File: tb/tb_btb_sa_core.sv
module tb_btb_sa_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ready;
    logic        req_valid = 1'b0;
    logic [63:0] req_pc = '0;
    logic [63:0] req_hist = '0;
    logic        resp_valid;
    logic        resp_hit;
    logic [63:0] resp_target;
    logic        resp_is_br;
    logic        resp_is_jal;
    logic        update_valid = 1'b0;
    logic [63:0] update_pc = '0;
    logic [63:0] update_hist = '0;
    logic [63:0] update_target = '0;
    logic        update_is_br = 1'b0;
    logic        update_is_jal = 1'b0;

    typedef struct {
        logic        hit;
        logic [63:0] tgt;
        logic        br;
        logic        jal;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b1;

    btb_sa_core dut (
        .clock(clock), .reset(reset), .ready(ready),
        .req_valid(req_valid), .req_pc(req_pc), .req_hist(req_hist),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_target(resp_target),
        .resp_is_br(resp_is_br), .resp_is_jal(resp_is_jal),
        .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
        .update_target(update_target), .update_is_br(update_is_br), .update_is_jal(update_is_jal)
    );

    always #5 clock = ~clock;

    // Monitor: compare every presented response against the oldest expectation.
    always @(negedge clock) begin
        if (mon_on) begin
            if (resp_valid) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 with no pending request");
                end else begin
                    e = exp_q.pop_front();
                    if (resp_hit !== e.hit || resp_target !== e.tgt ||
                        resp_is_br !== e.br || resp_is_jal !== e.jal) begin
                        errors++;
                        $display("FAIL resp: got hit=%b tgt=%h br=%b jal=%b, want hit=%b tgt=%h br=%b jal=%b",
                                 resp_hit, resp_target, resp_is_br, resp_is_jal, e.hit, e.tgt, e.br, e.jal);
                    end
                end
            end else if (resp_hit || resp_target != 0 || resp_is_br || resp_is_jal) begin
                checks++;
                errors++;
                $display("FAIL idle_resp: fields nonzero while resp_valid=0 (hit=%b tgt=%h)", resp_hit, resp_target);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic set_upd(input logic [63:0] pc, input logic [63:0] tgt, input logic br, input logic jal);
        update_valid = 1'b1;
        update_pc = pc;
        update_target = tgt;
        update_is_br = br;
        update_is_jal = jal;
    endtask

    task automatic set_req(input logic [63:0] pc, input logic hit, input logic [63:0] tgt,
                           input logic br, input logic jal);
        exp_t e;
        req_valid = 1'b1;
        req_pc = pc;
        e.hit = hit; e.tgt = tgt; e.br = br; e.jal = jal;
        exp_q.push_back(e);
    endtask

    task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic br, input logic jal);
        set_upd(pc, tgt, br, jal);
        tick();
    endtask

    task automatic req(input logic [63:0] pc, input logic hit, input logic [63:0] tgt,
                       input logic br, input logic jal);
        set_req(pc, hit, tgt, br, jal);
        tick();
    endtask

    // Counts cycles from now until ready rises; expects 64 (ready on the 65th cycle).
    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL %s: ready after %0d init cycles, want 64", name, n);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b resp_valid=%b, want 0 0", ready, resp_valid);
        end
    endtask

    initial begin
        // 1: reset state, init length, lookup during init
        tick();
        reset = 1'b0;
        checks++;
        if (ready !== 1'b0 || resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_target !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b resp_valid=%b hit=%b tgt=%h, want all 0",
                     ready, resp_valid, resp_hit, resp_target);
        end
        set_req(64'h1000, 1'b0, 64'h0, 1'b0, 1'b0);
        wait_ready("init_len");

        // 2: basic train and hit
        upd(64'h8000_1000, 64'h8000_2000, 1'b1, 1'b0);
        req(64'h8000_1000, 1'b1, 64'h8000_2000, 1'b1, 1'b0);

        // 3: round-robin eviction in set 0
        pulse_reset();
        wait_ready("init_len_s3");
        upd(64'h1000, 64'hA000, 1'b1, 1'b0);
        upd(64'h1100, 64'hA100, 1'b0, 1'b1);
        upd(64'h1200, 64'hA200, 1'b1, 1'b0);
        req(64'h1000, 1'b0, 64'h0, 1'b0, 1'b0);
        req(64'h1100, 1'b1, 64'hA100, 1'b0, 1'b1);
        req(64'h1200, 1'b1, 64'hA200, 1'b1, 1'b0);

        // 4: read-before-write on the same entry
        set_req(64'h3000, 1'b0, 64'h0, 1'b0, 1'b0);
        set_upd(64'h3000, 64'h4000, 1'b0, 1'b1);
        tick();
        req(64'h3000, 1'b1, 64'h4000, 1'b0, 1'b1);

        // 5: re-update keeps pointer, next new tag evicts way 0
        pulse_reset();
        wait_ready("init_len_s5");
        upd(64'h1000, 64'h1111, 1'b1, 1'b0);
        upd(64'h1100, 64'h2222, 1'b1, 1'b0);
        upd(64'h1000, 64'h5555, 1'b0, 1'b1);
        req(64'h1000, 1'b1, 64'h5555, 1'b0, 1'b1);
        req(64'h1100, 1'b1, 64'h2222, 1'b1, 1'b0);
        upd(64'h1300, 64'h3333, 1'b1, 1'b0);
        req(64'h1000, 1'b0, 64'h0, 1'b0, 1'b0);
        req(64'h1100, 1'b1, 64'h2222, 1'b1, 1'b0);
        req(64'h1300, 1'b1, 64'h3333, 1'b1, 1'b0);

        // 6: reset mid-run wipes everything, including first and last sets
        upd(64'h2004, 64'h20, 1'b0, 1'b1);
        upd(64'h3FFC, 64'h3F, 1'b1, 1'b0);
        req(64'h2004, 1'b1, 64'h20, 1'b0, 1'b1);
        req(64'h3FFC, 1'b1, 64'h3F, 1'b1, 1'b0);
        tick();
        pulse_reset();
        wait_ready("init_len_s6");
        req(64'h1100, 1'b0, 64'h0, 1'b0, 1'b0);
        req(64'h1300, 1'b0, 64'h0, 1'b0, 1'b0);
        req(64'h2004, 1'b0, 64'h0, 1'b0, 1'b0);
        req(64'h3FFC, 1'b0, 64'h0, 1'b0, 1'b0);

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                tick();
                n++;
            end
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses never arrived, want 0", exp_q.size());
        end
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
